// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the dual-clock FIFO (read and write sides).
//   - MIN_SYNC_STAGES : smallest legal clock-domain-crossing chain length.
//   - bin2gray/gray2bin : width-generic pointer conversions. They work on
//     GRAY_MAX_W-bit values. Callers zero-extend narrower pointers and keep
//     the low bits of the result. Zero upper bits stay zero in both
//     directions, so truncating the result is exact.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int MIN_SYNC_STAGES = 2;
   localparam int GRAY_MAX_W      = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_n.sv
// -----------------------------------------------------------------------------
// sync_n
//   N-stage, WIDTH-bit flop chain used to bring a Gray pointer into the local
//   clock domain. The write side of the FIFO uses the same block.
// Ports
//   clk    in   local clock
//   reset  in   synchronous active-high; clears every stage to 0
//   din    in   WIDTH  asynchronous input (must be Gray coded)
//   dout   out  WIDTH  synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_n
   import fifo_pkg::*;
#(
   parameter int N     = MIN_SYNC_STAGES,
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [N];
   logic [WIDTH-1:0] stage_d [N];

   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < N; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            stage_q[i] <= '0;
         end else begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[N-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side pointer and flag generator for the dual-clock FIFO. It runs
//   entirely in the read clock domain. It owns the binary RAM read address
//   and the Gray read pointer sent to the write side. It synchronises the
//   incoming Gray write pointer and produces registered empty, almost-empty,
//   occupancy and underflow.
//
// Handshake: a read is accepted (rd_ok) on any rising edge where read_en=1
//   and empty_flag=0. Only accepted reads advance the pointer. read_en while
//   empty is ignored and has no side effects besides underflow.
//
// Configuration macro: FIFO_RD_UNDERFLOW_EN
//   defined     -> underflow is a sticky flag, set by read_en while empty,
//                  cleared only by reset.
//   not defined -> underflow is tied to 0.
//
// Ports
//   read_clock          in   sole clock
//   reset               in   synchronous active-high
//   read_en             in   read request
//   write_gray_pointer  in   PW  Gray write pointer, unsynchronised
//   almost_empty_level  in   PW  almost-empty threshold (quasi-static)
//   read_addr           out  ADDR_WIDTH binary RAM read address
//   read_gray           out  PW  Gray read pointer to the write domain
//   read_level          out  PW  occupancy seen from the read side
//   empty_flag          out  registered empty
//   almost_empty_flag   out  registered, level <= almost_empty_level
//   underflow           out  sticky underflow (see macro above)
//   (PW = ADDR_WIDTH+1; the extra MSB is the wrap bit)
// -----------------------------------------------------------------------------
module fifo_read_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  read_clock,
   input  logic                  reset,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH:0]   write_gray_pointer,
   input  logic [ADDR_WIDTH:0]   almost_empty_level,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic [ADDR_WIDTH:0]   read_gray,
   output logic [ADDR_WIDTH:0]   read_level,
   output logic                  empty_flag,
   output logic                  almost_empty_flag,
   output logic                  underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   // A chain shorter than the minimum is not a safe synchroniser, so an
   // undersized setting is raised to the minimum.
   localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

   logic [PW-1:0] rbin_q, rbin_d;
   logic [PW-1:0] rgray_q, rgray_d;
   logic [PW-1:0] level_q, level_d;
   logic          empty_q, empty_d;
   logic          aempty_q, aempty_d;
   logic [PW-1:0] wsync;
   logic          rd_ok;
   logic [GRAY_MAX_W-1:0] rgray_wide;
   logic [GRAY_MAX_W-1:0] wbin_wide;

   sync_n #(
      .N     (SYNC_N),
      .WIDTH (PW)
   ) u_wptr_sync (
      .clk   (read_clock),
      .reset (reset),
      .din   (write_gray_pointer),
      .dout  (wsync)
   );

   // All flags are computed from the next pointer value. Because of this
   // look-ahead, reading the last word raises empty on the same edge that
   // moves the pointer.
   always_comb begin
      rd_ok      = read_en & ~empty_q;
      rbin_d     = rd_ok ? rbin_q + PW'(1) : rbin_q;
      rgray_wide = bin2gray(GRAY_MAX_W'(rbin_d));
      rgray_d    = rgray_wide[PW-1:0];
      wbin_wide  = gray2bin(GRAY_MAX_W'(wsync));
      level_d    = wbin_wide[PW-1:0] - rbin_d;
      empty_d    = (rgray_d == wsync);
      aempty_d   = (level_d <= almost_empty_level);
   end

   always_ff @(posedge read_clock) begin
      if (reset) begin
         rbin_q   <= '0;
         rgray_q  <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         aempty_q <= 1'b1;
      end else begin
         rbin_q   <= rbin_d;
         rgray_q  <= rgray_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         aempty_q <= aempty_d;
      end
   end

`ifdef FIFO_RD_UNDERFLOW_EN
   logic underflow_q, underflow_d;

   always_comb begin
      underflow_d = underflow_q | (read_en & empty_q);
   end

   always_ff @(posedge read_clock) begin
      if (reset) begin
         underflow_q <= 1'b0;
      end else begin
         underflow_q <= underflow_d;
      end
   end

   assign underflow = underflow_q;
`else
   assign underflow = 1'b0;
`endif

   assign read_addr         = rbin_q[ADDR_WIDTH-1:0];
   assign read_gray         = rgray_q;
   assign read_level        = level_q;
   assign empty_flag        = empty_q;
   assign almost_empty_flag = aempty_q;

endmodule
